// File: rtl/toy_mem_line_master.sv
// Line-request initiator for a single-port word memory with 1-cycle read latency.
// Splits one line read/write into back-to-back word accesses and returns one response.
module toy_mem_line_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_vld,
  output logic                                 req_rdy,
  input  logic                                 req_wr,
  input  logic [ADDR_WIDTH-1:0]                req_addr,
  input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] req_wdata,
  output logic                                 rsp_vld,
  input  logic                                 rsp_rdy,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] rsp_rdata,
  output logic                                 mem_en,
  output logic                                 mem_wr_en,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wr_data,
  input  logic [DATA_WIDTH-1:0]                mem_rd_data,
  output logic [2:0]                           o_dbg_state
);

  localparam int LINE_WIDTH = DATA_WIDTH * WORDS_PER_LINE;
  localparam int CNT_W      = $clog2(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_DRAIN = 3'd2,
    S_WR    = 3'd3,
    S_RSP   = 3'd4
  } state_t;

  // Handshakes: a request transfers on a rising edge where req_vld && req_rdy;
  // a response transfers on a rising edge where rsp_vld && rsp_rdy. Once raised,
  // rsp_vld and rsp_rdata hold until that transfer edge.
  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   r_base, w_base_nxt;
  logic [LINE_WIDTH-1:0]   r_wdata, w_wdata_nxt;
  logic [LINE_WIDTH-1:0]   r_rdata, w_rdata_nxt;
  logic                    r_cap_vld, w_cap_vld_nxt;
  logic [CNT_W-1:0]        r_cap_idx, w_cap_idx_nxt;
  logic                    r_req_rdy, w_req_rdy_nxt;
  logic                    r_rsp_vld, w_rsp_vld_nxt;
  logic                    r_mem_en, w_mem_en_nxt;
  logic                    r_mem_wr_en, w_mem_wr_en_nxt;
  logic [ADDR_WIDTH-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_mem_wr_data, w_mem_wr_data_nxt;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_last;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_base_nxt        = r_base;
    w_wdata_nxt       = r_wdata;
    w_rdata_nxt       = r_rdata;
    w_req_rdy_nxt     = 1'b0;
    w_rsp_vld_nxt     = 1'b0;
    w_mem_en_nxt      = 1'b0;
    w_mem_wr_en_nxt   = 1'b0;
    w_mem_addr_nxt    = '0;
    w_mem_wr_data_nxt = '0;
    // A read issued this cycle returns data next cycle; remember which slot it fills.
    w_cap_vld_nxt     = r_mem_en & ~r_mem_wr_en;
    w_cap_idx_nxt     = r_cnt;

    if (r_cap_vld) begin
      w_rdata_nxt[int'(r_cap_idx)*DATA_WIDTH +: DATA_WIDTH] = mem_rd_data;
    end

    case (r_state)
      S_IDLE: begin
        w_req_rdy_nxt = 1'b1;
        if (req_vld && r_req_rdy) begin
          w_req_rdy_nxt     = 1'b0;
          w_base_nxt        = req_addr & ALIGN_MASK;
          w_wdata_nxt       = req_wdata;
          w_rdata_nxt       = '0;
          w_cnt_nxt         = '0;
          w_mem_en_nxt      = 1'b1;
          w_mem_wr_en_nxt   = req_wr;
          w_mem_addr_nxt    = req_addr & ALIGN_MASK;
          w_mem_wr_data_nxt = req_wr ? req_wdata[DATA_WIDTH-1:0] : '0;
          w_state_nxt       = req_wr ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (w_last) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_mem_en_nxt   = 1'b1;
          w_mem_addr_nxt = r_base + ADDR_WIDTH'(w_cnt_inc);
          w_cnt_nxt      = w_cnt_inc;
        end
      end
      S_DRAIN: begin
        w_cnt_nxt     = '0;
        w_rsp_vld_nxt = 1'b1;
        w_state_nxt   = S_RSP;
      end
      S_WR: begin
        if (w_last) begin
          w_cnt_nxt     = '0;
          w_rsp_vld_nxt = 1'b1;
          w_state_nxt   = S_RSP;
        end else begin
          w_mem_en_nxt      = 1'b1;
          w_mem_wr_en_nxt   = 1'b1;
          w_mem_addr_nxt    = r_base + ADDR_WIDTH'(w_cnt_inc);
          w_mem_wr_data_nxt = r_wdata[int'(w_cnt_inc)*DATA_WIDTH +: DATA_WIDTH];
          w_cnt_nxt         = w_cnt_inc;
        end
      end
      S_RSP: begin
        if (rsp_rdy) begin
          w_req_rdy_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_rsp_vld_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_base        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_cap_vld     <= 1'b0;
      r_cap_idx     <= '0;
      r_req_rdy     <= 1'b0;
      r_rsp_vld     <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_base        <= w_base_nxt;
      r_wdata       <= w_wdata_nxt;
      r_rdata       <= w_rdata_nxt;
      r_cap_vld     <= w_cap_vld_nxt;
      r_cap_idx     <= w_cap_idx_nxt;
      r_req_rdy     <= w_req_rdy_nxt;
      r_rsp_vld     <= w_rsp_vld_nxt;
      r_mem_en      <= w_mem_en_nxt;
      r_mem_wr_en   <= w_mem_wr_en_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_wr_data <= w_mem_wr_data_nxt;
    end
  end

  assign req_rdy     = r_req_rdy;
  assign rsp_vld     = r_rsp_vld;
  assign rsp_rdata   = r_rdata;
  assign mem_en      = r_mem_en;
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_wr_data;
  assign o_dbg_state = r_state;

endmodule
